// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32 control unit.
// Ports: clk/rst (sync, active-high); op/funct3/funct7b5/zero in;
// datapath mux selects, write enables, ALUControl, ImmSrc, debug
// state and RetireCount out.
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  state,
  output logic [31:0] RetireCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t      st_q;
  state_t      st_d;
  logic [31:0] retire_q;

  logic       pcupdate;
  logic       branch;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic [1:0] aluop;
  logic       retire;

  logic is_mem;
  logic is_r;
  logic is_i;
  logic is_jal;
  logic is_beq;

  assign is_mem = (op == OP_LW) | (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_jal = (op == OP_JAL);
  assign is_beq = (op == OP_BEQ);

  // Every retiring state has FETCH as its only successor.
  assign retire = (st_q == S_MEMWB)
                | (st_q == S_MEMWRITE)
                | (st_q == S_ALUWB)
                | (st_q == S_BEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_FETCH;
      retire_q <= '0;
    end else begin
      st_q <= st_d;
      if (retire) begin
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  always_comb begin
    st_d = S_FETCH;
    case (st_q)
      S_FETCH: st_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  st_d = S_MEMADR;
          is_r:    st_d = S_EXECR;
          is_i:    st_d = S_EXECI;
          is_jal:  st_d = S_JAL;
          is_beq:  st_d = S_BEQ;
          default: st_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          st_d = S_MEMREAD;
        end else begin
          st_d = S_MEMWRITE;
        end
      end
      S_MEMREAD:  st_d = S_MEMWB;
      S_MEMWB:    st_d = S_FETCH;
      S_MEMWRITE: st_d = S_FETCH;
      S_EXECR:    st_d = S_ALUWB;
      S_EXECI:    st_d = S_ALUWB;
      S_ALUWB:    st_d = S_FETCH;
      S_JAL:      st_d = S_ALUWB;
      S_BEQ:      st_d = S_FETCH;
      default:    st_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcupdate   = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    aluop      = 2'b00;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    case (st_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcupdate  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables are held off while reset is asserted.
  assign PCWrite  = ~rst & (pcupdate | (branch & zero));
  assign IRWrite  = ~rst & irwrite_s;
  assign RegWrite = ~rst & regwrite_s;
  assign MemWrite = ~rst & memwrite_s;

  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000: begin
            // sub only for R-type (op[5]) with bit 30 set
            if (op[5] & funct7b5) begin
              ALUControl = 3'b001;
            end else begin
              ALUControl = 3'b000;
            end
          end
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      (op == OP_SW):  ImmSrc = 2'b01;
      (op == OP_BEQ): ImmSrc = 2'b10;
      (op == OP_JAL): ImmSrc = 2'b11;
      default:        ImmSrc = 2'b00;
    endcase
  end

  assign state       = st_q;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random instruction stream vs instruction-level
// model, plus directed reset, branch, sub, illegal-op and wrap cases.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [3:0]  state;
  logic [31:0] RetireCount;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic [3:0]  exp_st;
  logic [31:0] m_ret;
  int          mw_cnt;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk),
    .rst(rst),
    .op(op),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .zero(zero),
    .PCWrite(PCWrite),
    .AdrSrc(AdrSrc),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .RegWrite(RegWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc(ImmSrc),
    .state(state),
    .RetireCount(RetireCount)
  );

  typedef struct packed {
    logic       pcu;
    logic       br;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
  } ctl_t;

  typedef struct packed {
    logic [2:0]      n;
    logic [4:0][3:0] s;
    logic            ret;
  } seq_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // Control table: what each state drives (unlisted fields are 0).
  function automatic ctl_t ctl_of(input logic [3:0] s);
    ctl_t c;
    c = '0;
    case (s)
      4'd0: begin
        c.irw = 1; c.pcu = 1; c.sb = 2'b10; c.res = 2'b10;
      end
      4'd1: begin c.sa = 2'b01; c.sb = 2'b01; end
      4'd2: begin c.sa = 2'b10; c.sb = 2'b01; end
      4'd3: begin c.adr = 1; end
      4'd4: begin c.res = 2'b01; c.rw = 1; end
      4'd5: begin c.adr = 1; c.mw = 1; end
      4'd6: begin c.sa = 2'b10; c.aop = 2'b10; end
      4'd7: begin c.rw = 1; end
      4'd8: begin c.sa = 2'b10; c.sb = 2'b01; c.aop = 2'b10; end
      4'd9: begin c.sa = 2'b01; c.sb = 2'b10; c.pcu = 1; end
      4'd10: begin c.sa = 2'b10; c.aop = 2'b01; c.br = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [1:0] aop,
                                         input logic [6:0] o,
                                         input logic [2:0] f3,
                                         input logic f7);
    logic [2:0] r;
    r = 3'b000;
    if (aop == 2'b01) r = 3'b001;
    else if (aop == 2'b10) begin
      case (f3)
        3'b000:  r = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010:  r = 3'b101;
        3'b110:  r = 3'b011;
        3'b111:  r = 3'b010;
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // State walk of one instruction, FETCH first; ret = retires.
  function automatic seq_t seq_of(input logic [6:0] o);
    seq_t q;
    q = '0;
    case (o)
      OP_LW:  begin q.n = 5; q.s = {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}; q.ret = 1; end
      OP_SW:  begin q.n = 4; q.s = {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}; q.ret = 1; end
      OP_R:   begin q.n = 4; q.s = {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}; q.ret = 1; end
      OP_I:   begin q.n = 4; q.s = {4'd0, 4'd7, 4'd8, 4'd1, 4'd0}; q.ret = 1; end
      OP_JAL: begin q.n = 4; q.s = {4'd0, 4'd7, 4'd9, 4'd1, 4'd0}; q.ret = 1; end
      OP_BEQ: begin q.n = 3; q.s = {4'd0, 4'd0, 4'd10, 4'd1, 4'd0}; q.ret = 1; end
      default: begin q.n = 2; q.s = {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}; q.ret = 0; end
    endcase
    return q;
  endfunction

  ctl_t c;

  always @(negedge clk) begin
    if (chk_en) begin
      c = ctl_of(exp_st);
      chk("state", 32'(state), 32'(exp_st));
      chk("PCWrite", 32'(PCWrite),
          32'(!rst && (c.pcu || (c.br && zero))));
      chk("IRWrite", 32'(IRWrite), 32'(!rst && c.irw));
      chk("RegWrite", 32'(RegWrite), 32'(!rst && c.rw));
      chk("MemWrite", 32'(MemWrite), 32'(!rst && c.mw));
      chk("AdrSrc", 32'(AdrSrc), 32'(c.adr));
      chk("ResultSrc", 32'(ResultSrc), 32'(c.res));
      chk("ALUSrcA", 32'(ALUSrcA), 32'(c.sa));
      chk("ALUSrcB", 32'(ALUSrcB), 32'(c.sb));
      chk("ALUControl", 32'(ALUControl),
          32'(alu_ref(c.aop, op, funct3, funct7b5)));
      chk("ImmSrc", 32'(ImmSrc), 32'(imm_ref(op)));
      chk("RetireCount", RetireCount, m_ret);
    end
  end

  task automatic half(input logic [3:0] es);
    exp_st = es;
    @(negedge clk);
    #1;
    mw_cnt += int'(MemWrite);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] es);
    half(es);
    fin();
  endtask

  task automatic run_instr(input logic [6:0] o);
    seq_t q;
    q = seq_of(o);
    op = o;
    for (int k = 0; k < int'(q.n); k++) begin
      funct3   = 3'($urandom);
      funct7b5 = 1'($urandom);
      zero     = 1'($urandom);
      step(q.s[k]);
    end
    if (q.ret) m_ret = m_ret + 32'd1;
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = OP_LW;
      1: o = OP_SW;
      2: o = OP_R;
      3: o = OP_I;
      4: o = OP_JAL;
      5: o = OP_BEQ;
      default: begin
        o = 7'($urandom);
        while (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
               o == OP_JAL || o == OP_BEQ) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; op = '0; funct3 = '0; funct7b5 = 0; zero = 0;
    m_ret = '0; exp_st = 4'd0; mw_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    step(4'd0);
    rst = 0;

    // lw: 0,1,2,3,4 then one retirement
    run_instr(OP_LW);
    chk("lw_retire_lit", RetireCount, 32'd1);

    // beq: taken and not-taken PCWrite in state 10
    op = OP_BEQ; funct3 = 3'b000; funct7b5 = 0; zero = 0;
    step(4'd0);
    step(4'd1);
    zero = 1;
    half(4'd10);
    chk("beq_z1_pcwrite_lit", 32'(PCWrite), 32'd1);
    chk("beq_aluctl_lit", 32'(ALUControl), 32'd1);
    zero = 0;
    #1;
    chk("beq_z0_pcwrite_lit", 32'(PCWrite), 32'd0);
    fin();
    m_ret = m_ret + 32'd1;

    // R-type funct3=000: sub vs add
    op = OP_R; funct3 = 3'b000; funct7b5 = 1;
    step(4'd0);
    step(4'd1);
    half(4'd6);
    chk("r_sub_lit", 32'(ALUControl), 32'd1);
    funct7b5 = 0;
    #1;
    chk("r_add_lit", 32'(ALUControl), 32'd0);
    fin();
    step(4'd7);
    m_ret = m_ret + 32'd1;
    chk("r_retire_lit", RetireCount, 32'd3);

    // unsupported opcode: 0,1,0 with no retirement
    run_instr(7'b1111111);
    half(4'd0);
    chk("illegal_noretire_lit", RetireCount, 32'd3);
    fin();
    step(4'd1);

    // random instruction stream
    for (int i = 0; i < 300; i++) begin
      run_instr(pick_op());
    end

    // reset asserted in MEMREAD
    op = OP_LW;
    step(4'd0);
    step(4'd1);
    step(4'd2);
    rst = 1;
    mw_cnt = 0;
    half(4'd3);
    chk("rst_memread_regwrite_lit", 32'(RegWrite), 32'd0);
    fin();
    m_ret = '0;
    half(4'd0);
    chk("rst_state_lit", 32'(state), 32'd0);
    chk("rst_retire_lit", RetireCount, 32'd0);
    fin();
    rst = 0;
    op = OP_I;
    half(4'd0);
    chk("post_rst_irwrite_lit", 32'(IRWrite), 32'd1);
    chk("post_rst_pcwrite_lit", 32'(PCWrite), 32'd1);
    fin();
    step(4'd1);
    step(4'd8);
    step(4'd7);
    m_ret = m_ret + 32'd1;

    // RetireCount wrap on sw completion
    op = OP_SW;
    mw_cnt = 0;
    step(4'd0);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    m_ret = 32'hFFFF_FFFF;
    step(4'd1);
    step(4'd2);
    step(4'd5);
    m_ret = m_ret + 32'd1;
    op = 7'b1111111;
    half(4'd0);
    chk("wrap_retire_lit", RetireCount, 32'd0);
    chk("sw_memwrite_once_lit", 32'(mw_cnt), 32'd1);
    fin();
    step(4'd1);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
